seq_divider_rd: RTL and testbench



---
 rtl/seq_divider_rd.sv | 109 ++++++++++
 tb/tb_seq_divider_rd.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_rd.sv
// Purpose: iterative unsigned restoring divider, quotient/remainder of a DIVIDEND_W / DIVISOR_W pair.
// Latency: result valid DIVIDEND_W edges after the accept edge; a zero divisor is flagged right after the accept edge.
// Backpressure: result is held in DONE until out_ready; in_ready only while idle.
//
// Ports:
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       : operand handshake, dividend + divisor sampled on accept
//   out_valid/out_ready     : result handshake
//   quotient, remainder     : unsigned result; div_by_zero marks a zero-divisor result
module seq_divider_rd #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVISOR_W-1:0]  dvsr_q;
  // Restored remainder is always < divisor, so it fits in DIVISOR_W bits;
  // the extra partial-remainder bit only exists in the shifted value below.
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVIDEND_W-1:0] qreg_q;
  logic                  dbz_q;

  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_step;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt_q == LAST_ITER) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One restoring step: shift the quotient MSB into the remainder, then
  // subtract the divisor if it fits (quotient bit 1) or keep it (bit 0).
  always_comb begin
    shifted  = {rem_q, qreg_q[DIVIDEND_W-1]};
    ge       = (shifted >= {1'b0, dvsr_q});
    rem_step = ge ? DIVISOR_W'(shifted - {1'b0, dvsr_q}) : shifted[DIVISOR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvsr_q <= '0;
      rem_q  <= '0;
      qreg_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt_q  <= '0;
            dvsr_q <= divisor;
            if (divisor == '0) begin
              qreg_q <= '1;
              rem_q  <= dividend[DIVISOR_W-1:0];
              dbz_q  <= 1'b1;
            end else begin
              qreg_q <= dividend;
              rem_q  <= '0;
              dbz_q  <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_step;
          qreg_q <= {qreg_q[DIVIDEND_W-2:0], ge};
          cnt_q  <= cnt_q + CNT_W'(1);
        end
        default: ;  // DONE: hold results
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = qreg_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_rd.sv
// Bench for seq_divider_rd: directed cases with literal expectations plus
// randomized operand pairs checked against an arithmetic reference model.
module tb_seq_divider_rd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference results for the operation currently in flight.
  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_z;
  int          exp_lat;

  seq_divider_rd #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Arithmetic model: plain division, zero divisor yields all-ones quotient
  // and the low dividend byte as remainder.
  task automatic model(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0) begin
      exp_q = 16'hFFFF; exp_r = a[7:0]; exp_z = 1'b1; exp_lat = 0;
    end else begin
      exp_q = a / 16'(b); exp_r = 8'(a % 16'(b)); exp_z = 1'b0; exp_lat = 16;
    end
  endtask

  // Compare process: every cycle the result is presented, and every cycle
  // reset is held, outputs must match.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
    end else if (out_valid) begin
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("div_by_zero", div_by_zero, exp_z);
      chk("in_ready_in_done", in_ready, 0);
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input logic early_rdy);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("in_ready_wait", in_ready, 1);
    model(a, b);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    // Garbage on the inputs while busy must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    out_ready = early_rdy;
  endtask

  task automatic wait_result();
    int cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("latency", cyc, exp_lat);
    in_valid = 1'b0;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_q_held", quotient, exp_q);
    chk("post_hs_r_held", remainder, exp_r);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic early_rdy, input int stall);
    start_op(a, b, early_rdy);
    wait_result();
    if (!early_rdy) repeat (stall) begin @(posedge clk); #1; end
    release_op();
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 65025 / 255
    start_op(16'd65025, 8'd255, 1'b0);
    wait_result();
    chk("tp1_q", quotient, 255);
    chk("tp1_r", remainder, 0);
    chk("tp1_z", div_by_zero, 0);
    release_op();

    // Assorted directed pairs, literal expectations.
    start_op(16'd1000, 8'd7, 1'b0);  wait_result();
    chk("tp2a_q", quotient, 142);   chk("tp2a_r", remainder, 6);   release_op();
    start_op(16'd65535, 8'd1, 1'b0); wait_result();
    chk("tp2b_q", quotient, 65535); chk("tp2b_r", remainder, 0);   release_op();
    start_op(16'd5, 8'd200, 1'b0);   wait_result();
    chk("tp2c_q", quotient, 0);     chk("tp2c_r", remainder, 5);   release_op();

    // Zero divisor: result right after the accept edge.
    start_op(16'd100, 8'd0, 1'b0);   wait_result();
    chk("tp3_q", quotient, 16'hFFFF); chk("tp3_r", remainder, 100);
    chk("tp3_z", div_by_zero, 1);    release_op();

    // Backpressure: 10 stalled cycles, then handshake and back-to-back op.
    start_op(16'd12345, 8'd99, 1'b0); wait_result();
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_q", quotient, 124);
    chk("bp_r", remainder, 69);
    release_op();
    start_op(16'd40000, 8'd3, 1'b0); wait_result();
    chk("b2b_q", quotient, 13333);  chk("b2b_r", remainder, 1);    release_op();

    // Asynchronous reset in the middle of a computation.
    start_op(16'd50000, 8'd200, 1'b0);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_q", quotient, 0);
    chk("async_rst_r", remainder, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_op(16'd50000, 8'd200, 1'b0); wait_result();
    chk("tp5_q", quotient, 250);    chk("tp5_r", remainder, 0);    release_op();

    // Products of 8-bit values must divide back exactly.
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a * 16'(b), b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      chk("prod_q", quotient, a);
    end

    // Random 16/8 pairs, occasionally a zero divisor.
    for (int i = 0; i < 1200; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
